// File: rtl/pio_pkg.sv
// Shared constants for the Avalon-MM PIO: register offsets, edge and IRQ mode encodings.
package pio_pkg;

    localparam int unsigned PIO_ADDR_W = 3;
    localparam int unsigned PIO_BUS_W  = 32;

    localparam logic [PIO_ADDR_W-1:0] PIO_DATA_OFS    = 3'd0;
    localparam logic [PIO_ADDR_W-1:0] PIO_DIR_OFS     = 3'd1;
    localparam logic [PIO_ADDR_W-1:0] PIO_IRQMASK_OFS = 3'd2;
    localparam logic [PIO_ADDR_W-1:0] PIO_EDGECAP_OFS = 3'd3;
    localparam logic [PIO_ADDR_W-1:0] PIO_OUTSET_OFS  = 3'd4;
    localparam logic [PIO_ADDR_W-1:0] PIO_OUTCLR_OFS  = 3'd5;

    localparam int unsigned EDGE_NONE = 0;
    localparam int unsigned EDGE_RISE = 1;
    localparam int unsigned EDGE_FALL = 2;
    localparam int unsigned EDGE_ANY  = 3;

    localparam int unsigned IRQ_NONE  = 0;
    localparam int unsigned IRQ_LEVEL = 1;
    localparam int unsigned IRQ_EDGE  = 2;

endpackage

// File: rtl/avalon_pio_irq_if.sv
// Avalon-MM slave bus bundle for the PIO register file.
interface avalon_pio_irq_if;
    import pio_pkg::*;

    logic [PIO_ADDR_W-1:0] address;
    logic                  chipselect;
    logic                  write_n;
    logic [PIO_BUS_W-1:0]  writedata;
    logic [PIO_BUS_W-1:0]  readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/pio_sync_edge.sv
// Input synchroniser chain, previous-value register and per-bit edge event vector.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_in,
    output logic [WIDTH-1:0] edge_event_c
);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]                  prev_q;

    // Stage 0 samples the pad; the last stage is the clean synchronous value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_in = sync_q[SYNC_STAGES-1];

    generate
        if (EDGE_TYPE == EDGE_RISE) begin : g_rise
            assign edge_event_c = sync_in & ~prev_q;
        end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
            assign edge_event_c = ~sync_in & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin : g_any
            assign edge_event_c = sync_in ^ prev_q;
        end else begin : g_none
            logic [WIDTH-1:0] unused_prev;
            assign unused_prev  = prev_q;
            assign edge_event_c = '0;
        end
    endgenerate

endmodule

// File: rtl/avalon_pio_irq.sv
// Parametrised Avalon-MM GPIO with direction, edge capture, IRQ mask and IRQ output.
// Optional atomic out_port set/clear at offsets 4/5 when PIO_OUTSET_CLEAR_EN is defined.
module avalon_pio_irq
    import pio_pkg::*;
#(
    parameter int unsigned      WIDTH       = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter int unsigned      EDGE_TYPE   = EDGE_RISE,
    parameter int unsigned      IRQ_TYPE    = IRQ_EDGE
) (
    input  logic             clk,
    input  logic             reset_n,
    avalon_pio_irq_if.slave  bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] edge_event_c;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecap_q;

    logic             wr_en_c;
    logic [WIDTH-1:0] wd_c;
    logic [WIDTH-1:0] clr_c;
    logic [WIDTH-1:0] out_next_c;
    logic [WIDTH-1:0] irqmask_next_c;
    logic [WIDTH-1:0] edgecap_next_c;
    logic [WIDTH-1:0] irq_src_c;
    logic             irq_next_c;
    logic [PIO_BUS_W-1:0] rd_c;
    logic             unused_wd;

    pio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_port      (in_port),
        .sync_in      (sync_in),
        .edge_event_c (edge_event_c)
    );

    assign wr_en_c   = bus.chipselect & ~bus.write_n;
    assign wd_c      = bus.writedata[WIDTH-1:0];
    assign unused_wd = ^bus.writedata;
    assign clr_c     = (wr_en_c && bus.address == PIO_EDGECAP_OFS) ? wd_c : '0;

    // Output data register next value, including optional atomic set/clear.
    always_comb begin
        out_next_c = out_port;
        if (wr_en_c && bus.address == PIO_DATA_OFS) begin
            out_next_c = wd_c;
        end
`ifdef PIO_OUTSET_CLEAR_EN
        if (wr_en_c && bus.address == PIO_OUTSET_OFS) begin
            out_next_c = out_port | wd_c;
        end
        if (wr_en_c && bus.address == PIO_OUTCLR_OFS) begin
            out_next_c = out_port & ~wd_c;
        end
`endif
    end

    assign irqmask_next_c = (wr_en_c && bus.address == PIO_IRQMASK_OFS) ? wd_c : irqmask_q;

    // Sticky capture: a new event in the same cycle as a clear-write keeps the bit set.
    assign edgecap_next_c = (EDGE_TYPE == EDGE_NONE) ? '0
                          : ((edgecap_q & ~clr_c) | edge_event_c);

    // New captures raise irq a cycle after edgecapture; clears and mask writes drop it at once.
    assign irq_src_c = (IRQ_TYPE == IRQ_LEVEL) ? sync_in
                     : (IRQ_TYPE == IRQ_EDGE)  ? (edgecap_q & ~clr_c)
                     : '0;
    assign irq_next_c = |(irq_src_c & irqmask_next_c);

    always_comb begin
        rd_c = '0;
        case (bus.address)
            PIO_DATA_OFS:    rd_c = PIO_BUS_W'((sync_in & ~oe_port) | (out_port & oe_port));
            PIO_DIR_OFS:     rd_c = PIO_BUS_W'(oe_port);
            PIO_IRQMASK_OFS: rd_c = PIO_BUS_W'(irqmask_q);
            PIO_EDGECAP_OFS: rd_c = PIO_BUS_W'(edgecap_q);
            default:         rd_c = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port     <= RESET_VALUE;
            oe_port      <= '0;
            irqmask_q    <= '0;
            edgecap_q    <= '0;
            irq          <= 1'b0;
            bus.readdata <= '0;
        end else begin
            out_port     <= out_next_c;
            if (wr_en_c && bus.address == PIO_DIR_OFS) begin
                oe_port <= wd_c;
            end
            irqmask_q    <= irqmask_next_c;
            edgecap_q    <= edgecap_next_c;
            irq          <= irq_next_c;
            bus.readdata <= rd_c;
        end
    end

endmodule
